// File: rtl/timer_pkg.sv
// Shared types and default sizes for the down-counting timer.
package timer_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WIDTH_DEF      = 8;
  localparam int PRESCALE_W_DEF = 8;
endpackage

// File: rtl/down_timer_tick_gen.sv
// Prescaler for down_timer: emits one tick every prescale+1 enabled cycles while running.
module tick_gen
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] pcnt;

  // prescale is compared live; lowering it below pcnt skips ticks until pcnt wraps.
  assign tick = run && enable && (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (run && enable) begin
      if (pcnt == prescale) pcnt <= '0;
      else                  pcnt <= pcnt + PRESCALE_W'(1);
    end
  end
endmodule

// File: rtl/down_timer.sv
// Programmable down timer: load, prescaled decrement, one-cycle tc pulse and sticky irq.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  auto_reload,
  input  logic                  irq_ack,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  irq,
  output logic                  busy
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] out_d;
  logic             tc_d, irq_d;
  logic             tick;

  tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q == RUN),
    .enable   (enable),
    .clear    (load),
    .prescale (prescale),
    .tick     (tick)
  );

  // irq handshake: irq rises on expiry and stays high until a cycle with irq_ack=1;
  // an expiry in that same cycle wins, so no expiry is ever lost to an ack.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    out_d    = out;
    tc_d     = 1'b0;
    irq_d    = irq;
    if (irq_ack) irq_d = 1'b0;
    if (load) begin
      out_d    = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? RUN : IDLE;
    end else if (state_q == RUN && tick) begin
      if (out == WIDTH'(1)) begin
        tc_d  = 1'b1;
        irq_d = 1'b1;
        if (auto_reload) begin
          out_d = reload_q;
        end else begin
          out_d   = '0;
          state_d = IDLE;
        end
      end else begin
        out_d = out - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      reload_q <= '0;
      out      <= '0;
      tc       <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      out      <= out_d;
      tc       <= tc_d;
      irq      <= irq_d;
    end
  end

  assign busy = (state_q == RUN);
endmodule

// File: tb/tb_down_timer.sv
// Directed-vector bench for down_timer (WIDTH=8, PRESCALE_W=8).
module tb_down_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic [7:0] prescale = '0;
  logic       auto_reload = 1'b0;
  logic       irq_ack = 1'b0;
  logic [7:0] out;
  logic       tc, irq, busy;

  int vectors_applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .prescale    (prescale),
    .auto_reload (auto_reload),
    .irq_ack     (irq_ack),
    .out         (out),
    .tc          (tc),
    .irq         (irq),
    .busy        (busy)
  );

  typedef struct {
    string      tag;
    logic       rst, ld;
    logic [7:0] lv, ps;
    logic       ar, en, ack;
    logic [7:0] eo;
    logic       etc, eirq, ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic rst, input logic ld,
                     input logic [7:0] lv, input logic [7:0] ps,
                     input logic ar, input logic en, input logic ack,
                     input logic [7:0] eo, input logic etc, input logic eirq,
                     input logic ebusy);
    vec_t v;
    v.tag = tag; v.rst = rst; v.ld = ld; v.lv = lv; v.ps = ps;
    v.ar = ar; v.en = en; v.ack = ack;
    v.eo = eo; v.etc = etc; v.eirq = eirq; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [7:0] lv,
                       input logic [7:0] ps, input logic ar, input logic en,
                       input logic ack);
    reset = rst; load = ld; load_value = lv; prescale = ps;
    auto_reload = ar; enable = en; irq_ack = ack;
  endtask

  task automatic check(input string tag, input logic [7:0] eo, input logic etc,
                       input logic eirq, input logic ebusy);
    vectors_applied++;
    if (out !== eo || tc !== etc || irq !== eirq || busy !== ebusy) begin
      miscompares++;
      $display("FAIL %s: got out=%0d tc=%b irq=%b busy=%b, want out=%0d tc=%b irq=%b busy=%b",
               tag, out, tc, irq, busy, eo, etc, eirq, ebusy);
    end
  endtask

  initial begin
    int n;
    // Reset, then idle with all inputs low.
    for (int i = 0; i < 2; i++) add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // One-shot, load 5, prescale 0.
    add("os_load", 0, 1, 5, 0, 0, 1, 0, 5, 0, 0, 1);
    add("os_4",    0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 1);
    add("os_3",    0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1);
    add("os_2",    0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    add("os_1",    0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    add("os_exp",  0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    add("os_hold", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    add("os_ack",  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Load 2, prescale 3, with a 10-cycle enable gap after two enabled cycles.
    add("ps_load", 0, 1, 2, 3, 0, 1, 0, 2, 0, 0, 1);
    add("ps_c1",   0, 0, 0, 3, 0, 1, 0, 2, 0, 0, 1);
    add("ps_c2",   0, 0, 0, 3, 0, 1, 0, 2, 0, 0, 1);
    for (int i = 0; i < 10; i++) add("ps_gap", 0, 0, 0, 3, 0, 0, 0, 2, 0, 0, 1);
    add("ps_c3",   0, 0, 0, 3, 0, 1, 0, 2, 0, 0, 1);
    add("ps_c4",   0, 0, 0, 3, 0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add("ps_c5_7", 0, 0, 0, 3, 0, 1, 0, 1, 0, 0, 1);
    add("ps_exp",  0, 0, 0, 3, 0, 1, 0, 0, 1, 1, 0);
    add("ps_ack",  0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    // Auto-reload 3, prescale 0, ack tests and load-in-expiry.
    add("ar_load", 0, 1, 3, 0, 1, 1, 0, 3, 0, 0, 1);
    add("ar_2",    0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 1);
    add("ar_1",    0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    add("ar_exp1", 0, 0, 0, 0, 1, 1, 0, 3, 1, 1, 1);
    add("ar_2b",   0, 0, 0, 0, 1, 1, 0, 2, 0, 1, 1);
    add("ar_ack",  0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1);
    add("ar_ackex",0, 0, 0, 0, 1, 1, 1, 3, 1, 1, 1);
    add("ar_2c",   0, 0, 0, 0, 1, 1, 0, 2, 0, 1, 1);
    add("ar_ack2", 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1);
    add("ld_in_ex",0, 1, 7, 0, 1, 1, 0, 7, 0, 0, 1);
    add("ar_6",    0, 0, 0, 0, 1, 1, 0, 6, 0, 0, 1);
    add("mid_rst", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add("post_rst",0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Loading zero stays idle.
    add("ld_zero", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add("zero_h1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add("zero_h2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].ps, vecs[i].ar,
            vecs[i].en, vecs[i].ack);
      @(posedge clk); #1;
      check(vecs[i].tag, vecs[i].eo, vecs[i].etc, vecs[i].eirq, vecs[i].ebusy);
    end

    // Bounded wait: load 4 with prescale 1 must expire exactly 8 cycles after load.
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 4, 1, 0, 1, 0);
    @(posedge clk); #1;
    check("seq_load", 4, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1, 0);
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      n++;
      if (tc) break;
    end
    vectors_applied++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL seq_latency: got tc after %0d cycles, want 8", n);
    end
    check("seq_expired", 0, 1, 1, 0);
    // Loading zero with irq pending must leave irq set and produce no tc.
    drive(0, 1, 0, 1, 0, 1, 0);
    @(posedge clk); #1;
    check("seq_ld0_irq", 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    @(posedge clk); #1;
    check("seq_ld0_hold", 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Programmable down-counting timer: the count-down, expiry-signalling counterpart to the free-running up counter already in the core.
- Loads a start value, decrements once per prescaled tick, and flags expiry with a one-cycle terminal-count pulse plus a sticky interrupt.
- The interrupt is cleared by an acknowledge handshake.
- Sits beside the priRV32 core as the timer-interrupt source; optional auto-reload gives a periodic tick.

Parameters:
- WIDTH, 8, counter and load value width in bits.
- PRESCALE_W, 8, prescaler divide-value width in bits.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; low freezes prescaler and counter.
- load  input  1  load strobe; captures load_value.
- load_value  input  WIDTH  start/reload value.
- prescale  input  PRESCALE_W  tick every prescale+1 enabled cycles.
- auto_reload  input  1  1 = reload on expiry and keep running; 0 = one-shot.
- irq_ack  input  1  clears irq.
- out  output  WIDTH  current count.
- tc  output  1  one-cycle terminal-count pulse.
- irq  output  1  sticky expiry interrupt.
- busy  output  1  high while in state RUN.

Behaviour:
- Interface decision: one clock, clk; synchronous active-high reset, reset.
- All outputs are registered.
- Reset (sampled on clk edge): out=0, tc=0, irq=0, busy=0, prescaler count pcnt=0, reload register=0, state=IDLE.
- Reset has priority over every other input, including mid-run.
- States are IDLE and RUN. busy = (state==RUN).
- Load (priority below reset):
  - out<=load_value, reload register<=load_value, pcnt<=0.
  - Next state is RUN if load_value!=0, else IDLE.
  - Loading 0 produces no tc and leaves irq unchanged.
  - Load neither sets nor clears irq.
- Tick generation: in RUN with enable=1:
  - If pcnt==prescale, a tick occurs this cycle and pcnt<=0; otherwise pcnt<=pcnt+1.
  - prescale=0 means a tick every enabled cycle.
  - prescale is sampled live; if it is changed below the current pcnt, the compare misses until pcnt wraps at 2^PRESCALE_W. Software must change prescale only while idle.
- On a tick with out>1: out<=out-1.
- On a tick with out==1 (expiry):
  - tc<=1 for exactly the next cycle; irq<=1.
  - If auto_reload=1: out<=reload register, stay in RUN.
  - Else: out<=0, state<=IDLE.
- Expiry timing:
  - One-shot expiry occurs load_value*(prescale+1) enabled cycles after the load cycle.
  - Auto-reload period is reload*(prescale+1) enabled cycles.
- enable=0 holds pcnt, out and state. load and irq_ack are still honoured.
- IDLE ignores enable; out holds its value.
- irq_ack: irq<=0, unless expiry occurs in the same cycle, in which case set wins and irq stays 1.
- Simultaneous load and expiry tick: load wins; no tc, no irq set.
- Arithmetic is unsigned. The decrement never underflows, because out==0 is only possible in IDLE.

Decomposition:
- Package timer_pkg holds:
  - the state enum (IDLE, RUN);
  - the default WIDTH and PRESCALE_W localparams.
- One sub-module, tick_gen, contains the prescaler counter and tick compare.
  - Inputs: clk, reset, run, enable, clear, prescale. Output: tick.
- down_timer holds the count register, state machine, tc and irq logic.

Test Plan (WIDTH=8, PRESCALE_W=8):
- Reset for 2 cycles, then release with all inputs 0 -> out=0, tc=0, irq=0, busy=0 on every cycle.
- load_value=5, prescale=0, auto_reload=0, enable=1, 1-cycle load -> out reads 5,4,3,2,1,0 on consecutive cycles.
  - tc=1 only in the cycle out first reads 0; irq=1 and stays; busy falls with out=0.
- load_value=2, prescale=3 -> out changes every 4 cycles; expiry (out=0, tc=1) 8 cycles after load; enable low for 10 cycles mid-count delays expiry by exactly 10 cycles.
- auto_reload=1, load_value=3, prescale=0 -> out cycles 3,2,1,3,2,1...; tc pulses every 3 cycles; busy stays 1.
  - irq_ack asserted in a cycle with no expiry clears irq; irq_ack coincident with expiry leaves irq=1.
- Boundary cases:
  - load asserted in the expiry cycle -> no tc, irq unchanged, out=new load_value.
  - load_value=0 -> busy stays 0, no tc.
  - reset asserted mid-count -> next cycle all outputs return to reset values.
